// File: rtl/sisc_ifetch.sv
// sisc_ifetch: instruction fetch stage feeding the SISC datapath.
// Owns the fetch PC, a single-word memory request/ack handshake and the
// instruction register with a valid/ready hand-off to the consumer.
// Ports:
//   clk, rst_f          clock, synchronous active-high reset
//   br_taken, br_target redirect pulse and target word address
//   ir_ready            consumer accepts ir this cycle
//   mem_req, mem_addr   instruction memory request and word address
//   mem_ack, mem_rdata  memory response strobe and data
//   ir, ir_valid        instruction register and its valid flag
//   pc, npc             address of the instruction in ir, and pc+1
module sisc_ifetch #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              ir_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_n;
  logic              mem_req_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       ir_n;
  logic              ir_valid_n;
  logic [ADDR_W-1:0] pc_n, npc_n;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      ir         <= '0;
      ir_valid   <= 1'b0;
      pc         <= '0;
      npc        <= ADDR_W'(1);
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      mem_req    <= mem_req_n;
      mem_addr   <= mem_addr_n;
      ir         <= ir_n;
      ir_valid   <= ir_valid_n;
      pc         <= pc_n;
      npc        <= npc_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    ir_n       = ir;
    ir_valid_n = ir_valid;
    pc_n       = pc;
    npc_n      = npc;

    unique case (state_q)
      FETCH: begin
        if (!mem_req) begin
          // Idle FETCH cycle (after reset): launch the first request.
          mem_req_n = 1'b1;
          if (br_taken) begin
            fetch_pc_n = br_target;
            mem_addr_n = br_target;
          end else begin
            mem_addr_n = fetch_pc_q;
          end
        end else if (mem_ack) begin
          if (br_taken) begin
            // Data belongs to the abandoned path: drop it and re-request.
            fetch_pc_n = br_target;
            mem_addr_n = br_target;
          end else begin
            ir_n       = mem_rdata;
            ir_valid_n = 1'b1;
            pc_n       = fetch_pc_q;
            npc_n      = fetch_pc_q + ADDR_W'(1);
            fetch_pc_n = fetch_pc_q + ADDR_W'(1);
            mem_req_n  = 1'b0;
            state_n    = FULL;
          end
        end else if (br_taken) begin
          // Handshake must complete at the old address before redirecting.
          fetch_pc_n = br_target;
          state_n    = DRAIN;
        end
      end

      DRAIN: begin
        // Latest redirect wins, including one coinciding with the ack.
        if (br_taken) fetch_pc_n = br_target;
        if (mem_ack) begin
          state_n    = FETCH;
          mem_addr_n = br_taken ? br_target : fetch_pc_q;
        end
      end

      FULL: begin
        // Redirect flushes ir even if the consumer is ready this cycle.
        if (br_taken) begin
          ir_valid_n = 1'b0;
          fetch_pc_n = br_target;
          mem_req_n  = 1'b1;
          mem_addr_n = br_target;
          state_n    = FETCH;
        end else if (ir_ready) begin
          ir_valid_n = 1'b0;
          mem_req_n  = 1'b1;
          mem_addr_n = fetch_pc_q;
          state_n    = FETCH;
        end
      end

      default: begin
        state_n    = FETCH;
        mem_req_n  = 1'b0;
        ir_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sisc_ifetch.sv
// Bench for sisc_ifetch: memory model with programmable latency, consumer
// scoreboard of expected instruction addresses, and directed redirect/reset
// scenarios. A second instance covers RESET_PC at the top of the space.
module tb_sisc_ifetch;

  logic        clk;
  logic        rst_f, br_taken, ir_ready, mem_req, mem_ack, ir_valid;
  logic [15:0] br_target, mem_addr, pc, npc;
  logic [31:0] mem_rdata, ir;

  logic        b_rst, b_br, b_ready, b_mem_req, b_mem_ack, b_ir_valid;
  logic [15:0] b_target, b_mem_addr, b_pc, b_npc;
  logic [31:0] b_mem_rdata, b_ir;

  int unsigned n_pass, n_checks;
  logic [15:0] exp_q[$];
  logic [15:0] req_log[$];

  logic        auto_mem, busy;
  int          lat, wait_cnt;
  logic [15:0] cur_addr;

  sisc_ifetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_f(rst_f), .br_taken(br_taken), .br_target(br_target),
    .ir_ready(ir_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .pc(pc), .npc(npc)
  );

  sisc_ifetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_top (
    .clk(clk), .rst_f(b_rst), .br_taken(b_br), .br_target(b_target),
    .ir_ready(b_ready), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
    .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .ir(b_ir),
    .ir_valid(b_ir_valid), .pc(b_pc), .npc(b_npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [15:0] a);
    return {16'h1A2B ^ a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Memory model: latches the address when a request starts, checks it is
  // held, acks after lat extra cycles.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          busy = 1'b0;
        end
        if (rst_f) busy = 1'b0;
        else if (mem_req) begin
          if (!busy) begin
            busy = 1'b1;
            wait_cnt = 0;
            cur_addr = mem_addr;
            req_log.push_back(mem_addr);
          end else begin
            chk("mem_addr_hold", 32'(mem_addr), 32'(cur_addr));
          end
          if (wait_cnt == lat) begin
            mem_ack = 1'b1;
            mem_rdata = mem_data(cur_addr);
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Consumer scoreboard: every accepted instruction must be the next expected.
  initial begin
    logic [15:0] e, en;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_f && ir_valid && ir_ready && !br_taken) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pc", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          e  = exp_q.pop_front();
          en = e + 16'd1;
          chk("sb_pc", 32'(pc), 32'(e));
          chk("sb_ir", ir, mem_data(e));
          chk("sb_npc", 32'(npc), 32'(en));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Raise ir_ready until the scoreboard queue is drained, then drop it.
  task automatic run_expect(input int budget);
    ir_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #3;
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 ir_ready = 1'b0;
  endtask

  task automatic pulse_br(input logic [15:0] t, input logic rdy);
    br_taken = 1'b1;
    br_target = t;
    ir_ready = rdy;
    @(posedge clk);
    #1;
    br_taken = 1'b0;
    ir_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !ir_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(ir_valid), 32'd1);
  endtask

  initial begin
    n_pass = 0; n_checks = 0;
    auto_mem = 1'b1; busy = 1'b0; lat = 0; wait_cnt = 0; cur_addr = '0;
    rst_f = 1'b1; br_taken = 1'b0; br_target = '0; ir_ready = 1'b0;
    b_rst = 1'b1; b_br = 1'b0; b_target = '0; b_ready = 1'b0;
    b_mem_ack = 1'b0; b_mem_rdata = '0;

    // Reset state and zero-wait first fetch.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    rst_f = 1'b0;
    @(negedge clk);
    #1;
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    #1;
    chk("first_ir", ir, 32'h1A2B_0000);
    chk("first_valid", 32'(ir_valid), 32'd1);
    chk("first_pc", 32'(pc), 32'd0);
    chk("first_npc", 32'(npc), 32'd1);
    chk("first_req_drop", 32'(mem_req), 32'd0);
    exp_q.push_back(16'h0000);
    run_expect(20);

    // Redirect in FULL beats a simultaneous ir_ready.
    wait_valid("wv_full1", 20);
    pulse_br(16'h0010, 1'b0);
    wait_valid("wv_0x10", 20);
    chk("full_pc_0x10", 32'(pc), 32'h10);
    pulse_br(16'h0040, 1'b1);
    chk("flush_valid", 32'(ir_valid), 32'd0);
    chk("flush_req", 32'(mem_req), 32'd1);
    chk("flush_addr", 32'(mem_addr), 32'h40);
    exp_q.push_back(16'h0040);
    run_expect(30);

    // Three-cycle memory, in-order stream 5, 6, 7.
    lat = 2;
    wait_valid("wv_0x41", 30);
    req_log.delete();
    pulse_br(16'h0005, 1'b0);
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'h0007);
    run_expect(60);
    chk("req_log_len", 32'(req_log.size() >= 3), 32'd1);
    if (req_log.size() >= 3) begin
      chk("req_seq0", 32'(req_log[0]), 32'h5);
      chk("req_seq1", 32'(req_log[1]), 32'h6);
      chk("req_seq2", 32'(req_log[2]), 32'h7);
    end

    // Redirect while a fetch of 7 is waiting: drain it, then fetch 0x200.
    wait_valid("wv_0x8", 30);
    lat = 5;
    pulse_br(16'h0007, 1'b0);
    @(negedge clk);
    #1;
    req_log.delete();
    pulse_br(16'h0200, 1'b0);
    chk("drain_req", 32'(mem_req), 32'd1);
    chk("drain_addr", 32'(mem_addr), 32'h7);
    exp_q.push_back(16'h0200);
    run_expect(100);
    chk("drain_next_req", 32'(req_log.size() > 0 ? req_log[0] : 16'hDEAD), 32'h200);

    // Reset while a request to 3 is pending and acked in the reset cycle.
    wait_valid("wv_0x201", 60);
    auto_mem = 1'b0;
    mem_ack = 1'b0;
    pulse_br(16'h0003, 1'b0);
    chk("pend_addr", 32'(mem_addr), 32'h3);
    rst_f = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_0003;
    @(posedge clk);
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_valid", 32'(ir_valid), 32'd0);
    chk("mid_rst_ir", ir, 32'd0);
    rst_f = 1'b0;
    mem_ack = 1'b0;
    busy = 1'b0;
    lat = 0;
    auto_mem = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'd0);
    exp_q.push_back(16'h0000);
    run_expect(20);

    // RESET_PC = 0xFFFF: pc/npc wrap and the following request is 0.
    b_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("top_req", 32'(b_mem_req), 32'd1);
    chk("top_addr", 32'(b_mem_addr), 32'hFFFF);
    b_mem_ack = 1'b1;
    b_mem_rdata = mem_data(16'hFFFF);
    @(posedge clk);
    #1;
    b_mem_ack = 1'b0;
    chk("top_valid", 32'(b_ir_valid), 32'd1);
    chk("top_pc", 32'(b_pc), 32'hFFFF);
    chk("top_npc", 32'(b_npc), 32'h0);
    chk("top_ir", b_ir, mem_data(16'hFFFF));
    b_ready = 1'b1;
    @(posedge clk);
    #1;
    b_ready = 1'b0;
    chk("top_wrap_req", 32'(b_mem_req), 32'd1);
    chk("top_wrap_addr", 32'(b_mem_addr), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sisc_ifetch.md
Name: sisc_ifetch

Overview:
- Instruction fetch stage directly upstream of the SISC datapath top; produces the 32-bit `ir` that the datapath decodes (opcode ir[31:28], mm ir[27:24], registers ir[23:12]).
- Owns the fetch program counter, a single-word instruction memory request/acknowledge handshake, and the instruction register with a valid/ready hand-off to the consumer.
- Accepts branch redirects from ctrl and flushes or discards in-flight instructions accordingly.

Parameters:
- ADDR_W, 16, width of instruction word address and PCs.
- RESET_PC, 0, fetch address after reset (ADDR_W bits).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_f  in  1  reset, synchronous, active-high.
- br_taken  in  1  ctrl redirect request, single-cycle pulse.
- br_target  in  ADDR_W  redirect word address, valid when br_taken=1.
- ir_ready  in  1  consumer accepts the current ir this cycle.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ADDR_W  word address of the request.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  32  instruction word, valid when mem_ack=1.
- ir  out  32  instruction register to datapath.
- ir_valid  out  1  ir holds a live instruction.
- pc  out  ADDR_W  address of the instruction currently in ir.
- npc  out  ADDR_W  pc+1 modulo 2^ADDR_W.

Behaviour:
- Reset (rst_f=1 at an edge): state=FETCH, fetch_pc=RESET_PC, ir=0, ir_valid=0, pc=0, mem_req=0 in the cycle after the reset edge. Any mem_ack in a reset cycle is ignored.
- FSM has three states: FETCH, FULL and DRAIN. mem_req is registered and asserts the first cycle after reset deasserts.
- FETCH:
  - mem_req=1, mem_addr=fetch_pc. Both are held stable until mem_ack. An ack in the first request cycle (zero wait) is legal.
  - mem_ack with br_taken=0: ir<=mem_rdata, pc<=fetch_pc, ir_valid<=1, fetch_pc<=fetch_pc+1, go to FULL. mem_req=0 the next cycle.
  - br_taken with mem_ack=1 in the same cycle: discard data, fetch_pc<=br_target, stay in FETCH. The new request with the target address is issued the next cycle.
  - br_taken with mem_ack=0: fetch_pc<=br_target, go to DRAIN. mem_req and mem_addr stay unchanged until the ack; the handshake is never abandoned except by reset.
- DRAIN:
  - mem_req=1 at the old address.
  - On mem_ack: discard data, go to FETCH, and request fetch_pc the next cycle.
  - A further br_taken in DRAIN overwrites fetch_pc; the last redirect wins.
- FULL:
  - mem_req=0, ir_valid=1; ir and pc are held.
  - ir_ready=1: ir_valid<=0, go to FETCH.
  - br_taken=1: ir_valid<=0, fetch_pc<=br_target, go to FETCH. br_taken has priority over a simultaneous ir_ready; the instruction is flushed, not consumed.
- ir holds its last value when ir_valid=0. ctrl must qualify all use of ir with ir_valid.
- Arithmetic:
  - fetch_pc+1 and npc wrap modulo 2^ADDR_W; 2^ADDR_W−1 is followed by 0.
  - No overflow flag is produced.
- Throughput: at most one instruction per 2 cycles with zero-wait memory (ack cycle plus FULL cycle).
- Reset mid-transaction: mem_req drops the cycle after the reset edge. The memory model must tolerate an abandoned request.
- Unused state encoding recovers to FETCH at the next edge.

Test Plan:
- Reset release, zero-wait memory returning 32'h1A2B_0000 at addr 0 -> mem_req=1 with mem_addr=0 one cycle after release; next cycle ir=32'h1A2B_0000, ir_valid=1, pc=0, npc=1, mem_req=0.
- 3-cycle-latency memory, ir_ready held 1 -> mem_addr stays at 0x0005 for all wait cycles; ir_valid pulses for one cycle per instruction; addresses fetched are 5, 6, 7 in order.
- FULL with ir=instr@0x10, br_taken=1 with br_target=0x0040 and ir_ready=1 in the same cycle -> ir_valid=0 the next cycle; next mem_addr=0x0040; instr@0x10 is not re-presented.
- br_taken (target 0x0200) while a fetch of 0x0007 is waiting -> mem_addr stays 0x0007 until ack; the ack data never reaches ir; the next request is 0x0200 and ir eventually holds instr@0x0200 with pc=0x0200.
- With RESET_PC=16'hFFFF -> first ir has pc=16'hFFFF and npc=16'h0000; the next request address is 0x0000.
- rst_f=1 while a request to 0x0003 is pending, ack in the same cycle -> mem_req=0 the next cycle, ir_valid=0, ir=0; after release the first request is RESET_PC.
